fetch_pair_queue: RTL and testbench

//  Front-end instruction supplier for the dual-issue relayer. Fetches two 16-bit

---
 rtl/fetch_pair_queue.sv | 128 ++++++++++++
 tb/tb_fetch_pair_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_queue.sv
// Instruction fetch queue for the dual-issue relayer. It fetches 16-bit instruction
// pairs into a circular buffer, presents the oldest two, and retires 0/1/2 per cycle.
module fetch_pair_queue #(
  parameter int unsigned          DEPTH    = 8,
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       relay_stall,
  input  logic                       relay_single,
  output logic [15:0]                instr1_o,
  output logic [15:0]                instr2_o,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 2;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic              drop_next_q, drop_next_d;
  logic              odd_q, odd_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];

  logic [1:0]        avail, want, pop, push;
  logic [OCC_W-1:0]  occ;
  logic              req, fill;

  assign head_nx   = head_q + PTR_W'(1);
  assign instr1_o  = (count_q >= CNT_W'(1)) ? mem_q[head_q]  : 16'h0000;
  assign instr2_o  = (count_q >= CNT_W'(2)) ? mem_q[head_nx] : 16'h0000;
  assign q_count   = count_q;
  assign imem_req  = req;
  // Memory is addressed by pair base; an odd pc uses only the upper half.
  assign imem_addr = {pc_q[ADDR_W-1:1], 1'b0};

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_d        = pc_q;
    inflight_d  = 1'b0;
    drop_next_d = 1'b0;
    odd_d       = odd_q;
    mem_d       = mem_q;
    push        = 2'd0;

    avail = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    want  = relay_stall ? 2'd0 : (relay_single ? 2'd1 : 2'd2);
    pop   = (want < avail) ? want : avail;

    // In-flight credit is counted but this cycle's pop is not.
    occ  = OCC_W'(count_q) + (inflight_q ? OCC_W'(2) : OCC_W'(0)) + OCC_W'(2);
    req  = !rst && !redirect_valid && (occ <= OCC_W'(DEPTH));
    fill = inflight_q && !drop_next_q && !redirect_valid;

    if (fill) begin
      if (odd_q) begin
        mem_d[tail_q] = imem_rdata[31:16];
        push          = 2'd1;
      end else begin
        mem_d[tail_q]                = imem_rdata[15:0];
        mem_d[tail_q + PTR_W'(1)]    = imem_rdata[31:16];
        push                         = 2'd2;
      end
    end

    tail_d  = tail_q + PTR_W'(push);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (req) begin
      inflight_d = 1'b1;
      odd_d      = pc_q[0];
      pc_d       = pc_q[0] ? (pc_q + ADDR_W'(1)) : (pc_q + ADDR_W'(2));
    end

    // Redirect flushes everything and retargets fetch.
    if (redirect_valid) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      pc_d        = redirect_pc;
      drop_next_d = inflight_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      drop_next_q <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      drop_next_q <= drop_next_d;
      odd_q       <= odd_d;
    end
  end

  // Queue storage carries no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    count_d <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    CNT_W'(pop) <= count_q);

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue: per-cycle vector table plus wrap/redirect sequence.
module tb_fetch_pair_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        relay_stall;
  logic        relay_single;
  logic [15:0] instr1_o;
  logic [15:0] instr2_o;
  logic [3:0]  q_count;

  int tests  = 0;
  int failed = 0;

  fetch_pair_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .relay_stall    (relay_stall),
    .relay_single   (relay_single),
    .instr1_o       (instr1_o),
    .instr2_o       (instr2_o),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m(input logic [15:0] a);
    return 16'h8000 | a;
  endfunction

  // Instruction memory model: one-cycle read latency, pair at the given base.
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {m(imem_addr + 16'd1), m(imem_addr)};
  end

  typedef struct {
    logic        rst, stall, single, redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr, i1, i2;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic s, input logic g, input logic rd,
                              input logic [15:0] rpc, input logic rq, input logic [15:0] ad,
                              input logic [15:0] e1, input logic [15:0] e2, input logic [3:0] c);
    vec_t v;
    v.rst = r; v.stall = s; v.single = g; v.redir = rd; v.rpc = rpc;
    v.req = rq; v.addr = ad; v.i1 = e1; v.i2 = e2; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic s, input logic g, input logic rd,
                        input logic [15:0] rpc);
    rst = r; relay_stall = s; relay_single = g; redirect_valid = rd; redirect_pc = rpc;
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst stall single redir rpc | req addr i1 i2 cnt
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0000, 16'h0,   16'h0,   4'd0)); // c1
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0002, 16'h0,   16'h0,   4'd0));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, m(0),    m(1),    4'd2)); // first pair
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0006, m(2),    m(3),    4'd2));
    vq.push_back(mk(0,1,0,0,16'h0, 1,16'h0008, m(4),    m(5),    4'd2)); // stall begins
    vq.push_back(mk(0,1,0,0,16'h0, 1,16'h000A, m(4),    m(5),    4'd4));
    vq.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, m(4),    m(5),    4'd6));
    for (int k = 0; k < 7; k++)
      vq.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, m(4),  m(5),    4'd8)); // full, held
    vq.push_back(mk(0,0,0,0,16'h0, 0,16'h0000, m(4),    m(5),    4'd8)); // release
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h000C, m(6),    m(7),    4'd6));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h000E, m(8),    m(9),    4'd4));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0010, m(10),   m(11),   4'd4));
    vq.push_back(mk(0,0,1,0,16'h0, 1,16'h0012, m(12),   m(13),   4'd4)); // single issue
    vq.push_back(mk(0,0,1,0,16'h0, 0,16'h0000, m(13),   m(14),   4'd5));
    vq.push_back(mk(0,0,1,0,16'h0, 1,16'h0014, m(14),   m(15),   4'd6));
    vq.push_back(mk(0,0,1,0,16'h0, 0,16'h0000, m(15),   m(16),   4'd5)); // head 7 -> 0
    vq.push_back(mk(0,0,1,0,16'h0, 1,16'h0016, m(16),   m(17),   4'd6));
    vq.push_back(mk(0,0,0,1,16'h41,0,16'h0000, m(17),   m(18),   4'd5)); // redirect, req in flight
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0040, 16'h0,   16'h0,   4'd0));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0042, 16'h0,   16'h0,   4'd0));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0044, m(16'h41),16'h0,  4'd1)); // only mem[0x41]
    vq.push_back(mk(1,0,0,0,16'h0, 0,16'h0000, m(16'h42),m(16'h43),4'd2)); // reset mid-stream
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0000, 16'h0,   16'h0,   4'd0));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0002, 16'h0,   16'h0,   4'd0));
    vq.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, m(0),    m(1),    4'd2));

    set_in(1, 0, 0, 0, 16'h0);
    adv();
    chk("reset_i1",  32'(instr1_o), 32'h0);
    chk("reset_i2",  32'(instr2_o), 32'h0);
    chk("reset_cnt", 32'(q_count),  32'h0);
    chk("reset_req", 32'(imem_req), 32'h0);

    foreach (vq[i]) begin
      set_in(vq[i].rst, vq[i].stall, vq[i].single, vq[i].redir, vq[i].rpc);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vq[i].req));
      if (vq[i].req) chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vq[i].addr));
      chk($sformatf("v%0d_i1", i),  32'(instr1_o), 32'(vq[i].i1));
      chk($sformatf("v%0d_i2", i),  32'(instr2_o), 32'(vq[i].i2));
      chk($sformatf("v%0d_cnt", i), 32'(q_count),  32'(vq[i].cnt));
      adv();
    end

    // Back-to-back redirects to an odd pc, then a single pop shifts head odd so
    // steady pair issue walks the head onto DEPTH-1 and wraps.
    set_in(1, 0, 0, 0, 16'h0);
    adv();
    set_in(0, 1, 0, 1, 16'h0030);
    chk("w_redir1_req", 32'(imem_req), 32'h0);
    adv();
    set_in(0, 1, 0, 1, 16'h0041);
    chk("w_redir2_req", 32'(imem_req), 32'h0);
    adv();
    set_in(0, 1, 0, 0, 16'h0);
    chk("w_req40",  32'(imem_req),  32'h1);
    chk("w_addr40", 32'(imem_addr), 32'h40);
    adv();
    set_in(0, 1, 0, 0, 16'h0);
    chk("w_addr42", 32'(imem_addr), 32'h42);
    chk("w_cnt0",   32'(q_count),   32'h0);
    adv();
    set_in(0, 0, 1, 0, 16'h0);
    chk("w_odd_i1", 32'(instr1_o), 32'(m(16'h41)));
    chk("w_odd_i2", 32'(instr2_o), 32'h0);
    chk("w_odd_cnt", 32'(q_count), 32'h1);
    adv();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 0, 0, 16'h0);
      chk($sformatf("w%0d_i1", k),  32'(instr1_o), 32'(m(16'h42 + 16'(2*k))));
      chk($sformatf("w%0d_i2", k),  32'(instr2_o), 32'(m(16'h43 + 16'(2*k))));
      chk($sformatf("w%0d_cnt", k), 32'(q_count),  32'h2);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
